// File: rtl/bike_pkg.sv
// Shared bike definitions: orientation encoding and start-of-game headings.
// Used by the orientation input block and the display logic.
package bike_pkg;

  localparam int NUM_BIKES = 4;

  // Two-bit heading, clockwise from up.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } orient_t;

  // Headings loaded on reset and while the game is held.
  localparam orient_t START_BIKE1 = RIGHT;
  localparam orient_t START_BIKE2 = LEFT;
  localparam orient_t START_BIKE3 = DOWN;
  localparam orient_t START_BIKE4 = UP;

  // Start heading for bike index 0..3.
  function automatic orient_t start_orient(input int bike);
    case (bike)
      0:       return START_BIKE1;
      1:       return START_BIKE2;
      2:       return START_BIKE3;
      default: return START_BIKE4;
    endcase
  endfunction

  // Quarter turn clockwise; LEFT wraps to UP.
  function automatic orient_t turn_cw(input orient_t o);
    logic [1:0] v;
    v = o;
    v = v + 2'd1;
    return orient_t'(v);
  endfunction

  // Quarter turn counter-clockwise; UP wraps to LEFT.
  function automatic orient_t turn_ccw(input orient_t o);
    logic [1:0] v;
    v = o;
    v = v - 2'd1;
    return orient_t'(v);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw push button: 2-flop synchronizer, stability counter, and a
// registered one-cycle press strobe on an accepted 0->1 of the stable level.
// Releases are debounced the same way but produce no strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count disagreement cycles, accept the new level when the
  // count has run its full length without the input bouncing back.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking would collapse the sync chain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bike_orient_input.sv
// Turns debounced left/right button presses into per-bike orientation words.
// masterSwitch=0 holds every bike at its start heading and discards presses;
// the debouncers keep running so a button held across game start is ignored.
module bike_orient_input
  import bike_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        masterSwitch,
  input  logic [3:0]  btn_left,
  input  logic [3:0]  btn_right,
  output logic [31:0] bikeoneOrient_IN,
  output logic [31:0] biketwoOrient_IN,
  output logic [31:0] bikethreeOrient_IN,
  output logic [31:0] bikefourOrient_IN,
  output logic [3:0]  turn_pulse
);

  logic [NUM_BIKES-1:0] press_left;
  logic [NUM_BIKES-1:0] press_right;
  orient_t              orient_q [NUM_BIKES];
  orient_t              orient_d [NUM_BIKES];
  logic [NUM_BIKES-1:0] pulse_d;

  for (genvar i = 0; i < NUM_BIKES; i++) begin : g_bike
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_left (
      .clock (clock),
      .reset (reset),
      .btn   (btn_left[i]),
      .press (press_left[i])
    );

    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_right (
      .clock (clock),
      .reset (reset),
      .btn   (btn_right[i]),
      .press (press_right[i])
    );
  end

  // Next heading per bike; simultaneous left+right on one bike cancel out.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_BIKES; i++) begin
      orient_d[i] = orient_q[i];
      pulse_d[i]  = 1'b0;
      case ({press_left[i], press_right[i]})
        2'b01: begin
          orient_d[i] = turn_cw(orient_q[i]);
          pulse_d[i]  = 1'b1;
        end
        2'b10: begin
          orient_d[i] = turn_ccw(orient_q[i]);
          pulse_d[i]  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Heading registers and turn strobe; reset and a held game both restore
  // the start headings with no strobe.
  always_ff @(posedge clock) begin
    if (!reset || !masterSwitch) begin
      for (int i = 0; i < NUM_BIKES; i++) begin
        orient_q[i] <= start_orient(i);
      end
      turn_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_BIKES; i++) begin
        orient_q[i] <= orient_d[i];
      end
      turn_pulse <= pulse_d;
    end
  end

  assign bikeoneOrient_IN   = {30'b0, orient_q[0]};
  assign biketwoOrient_IN   = {30'b0, orient_q[1]};
  assign bikethreeOrient_IN = {30'b0, orient_q[2]};
  assign bikefourOrient_IN  = {30'b0, orient_q[3]};

endmodule

// File: doc/bike_orient_input.md
BIKE_ORIENT_INPUT -- requirements
Module: bike_orient_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable cycles required to accept a button level (5 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 18, meaning the width of each debounce counter; it SHALL hold DEBOUNCE_CYCLES.
REQ-003 SHALL have port clock, input, 1, the single system clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on the clock edge).
REQ-005 SHALL have port masterSwitch, input, 1, meaning game running (1) or game held (0).
REQ-006 SHALL have port btn_left, input, 4, raw asynchronous active-high left-turn buttons; bit i = bike i+1.
REQ-007 SHALL have port btn_right, input, 4, raw asynchronous active-high right-turn buttons; bit i = bike i+1.
REQ-008 SHALL have ports bikeoneOrient_IN, biketwoOrient_IN, bikethreeOrient_IN and bikefourOrient_IN, each output, 32, the registered orientation word written into the register file.
REQ-009 SHALL have port turn_pulse, output, 4, a one-cycle strobe for each bike whose orientation changed this cycle.

Function
REQ-010 Orientation encoding SHALL be 2 bits: 0 = up, 1 = right, 2 = down, 3 = left.
REQ-011 Each orientation output word SHALL be {30'b0, orient[1:0]}.
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Debounce SHALL work as follows.
- One counter per button (8 total).
- If the synchronized level differs from the stable level, the counter increments.
- If it equals the stable level, the counter clears to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level takes the synchronized value and the counter clears.
REQ-014 A press event SHALL be a 0->1 transition of a stable level, lasting exactly one cycle. Releases SHALL generate no event.
REQ-015 On a press event with masterSwitch=1, orientation SHALL update on the same clock edge that registers the event.
- Right press: orient+1 mod 4 (3 wraps to 0).
- Left press: orient-1 mod 4 (0 wraps to 3).
REQ-016 If left and right press events for one bike occur in the same cycle, that bike's orientation SHALL remain unchanged and turn_pulse SHALL stay 0.
REQ-017 Bikes SHALL be fully independent; simultaneous events on different bikes SHALL all be applied in the same cycle.
REQ-018 turn_pulse[i] SHALL be 1 for exactly the cycle after the orientation register of bike i changes, aligned with the new output value.
REQ-019 Latency SHALL be exactly DEBOUNCE_CYCLES+3 clock edges from a raw level change (held stable) to the updated orientation output.
REQ-020 While masterSwitch=0, all orientations SHALL be forced to their start values (REQ-023), press events SHALL be discarded, and turn_pulse SHALL be 0.
REQ-021 Debouncers SHALL keep running regardless of masterSwitch, so a button held through a masterSwitch 0->1 transition SHALL NOT produce a turn.
REQ-022 A turn SHALL NOT be gated by any other condition; a 180-degree reversal is only reachable by two separate presses.

Reset
REQ-023 On reset=0 at a clock edge, the following values SHALL load.
- Orientations: bike1 = 1 (right), bike2 = 3 (left), bike3 = 2 (down), bike4 = 0 (up).
- Synchronizer flops, stable levels and counters: 0.
- turn_pulse: 0.
REQ-024 Reset asserted mid-debounce or mid-turn SHALL abandon the operation with no pulse. Reset SHALL dominate masterSwitch and all press events.
REQ-025 After reset release, outputs SHALL hold their start values until a qualified press event occurs.

Structure
REQ-026 Orientation encodings (UP/RIGHT/DOWN/LEFT) and the four start orientations SHALL live in shared package bike_pkg, used by this block and the display logic.
REQ-027 Synchronizer, debounce counter and edge detect SHALL form one sub-module, btn_debounce, instantiated 8 times.
REQ-028 The orientation update and masterSwitch gating SHALL be in the top level.
REQ-029 All outputs SHALL be driven directly from flops.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 Reset then masterSwitch=1, no buttons -> outputs 1,3,2,0 and turn_pulse=0 for 50 cycles.
REQ-031 Hold btn_right[0]=1 -> bikeoneOrient_IN goes 1->2 exactly 7 edges after the raw change; turn_pulse=4'b0001 for one cycle; a held button gives no repeat.
REQ-032 Toggle btn_left[1] with a 2-cycle glitch -> no change. Three clean left presses on bike2 -> 3->2->1->0; a fourth press wraps 0->3.
REQ-033 Assert btn_left[2] and btn_right[2] on the same cycle -> bike3 stays 2 with no pulse. Same cycle, btn_right[3] -> bike4 goes 0->1.
REQ-034 Mid-game, turn bike1 to 3, then masterSwitch=0 -> bike1 returns to 1; press btn_right[0] while masterSwitch=0 -> no change. Hold a button across masterSwitch 0->1 -> no turn.
REQ-035 Assert reset=0 while btn_right[0] has been stable for 2 cycles -> no pulse; after release all outputs are 1,3,2,0.
